// File: rtl/pipe_stage_skid_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_skid_if
// Description : Valid/ready handshake bundle around one pipeline stage.
//               The upstream side (in_*) and the downstream side (out_*)
//               are carried together so that a stage is wired with a
//               single connection.
// Ports       : in_valid/in_ready/in_data    - upstream handshake + payload
//               out_valid/out_ready/out_data - downstream handshake + payload
// Modports    : slave  - the stage register itself
//               master - the environment (upstream producer and
//                        downstream consumer) around the stage
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_stage_skid_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_skid
// Description : Pipeline stage register with valid/ready handshake, a
//               2-entry skid buffer (main + skid), synchronous flush and
//               masking of control fields on bubbles.
// Ports       : clk      - clock, rising edge
//               rst_n    - asynchronous active-low reset
//               flush    - synchronous flush, overrides any transfer
//               bus      - handshake bundle (slave modport)
//               count    - occupancy 0..2
//               drop_cnt - saturating count of valid entries lost to flush
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_skid #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] CTRL_MASK  = '0,
  parameter bit               CLEAR_DATA = 1'b0,
  parameter int               CNT_W      = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  pipe_stage_skid_if.slave    bus,
  output logic [1:0]          count,
  output logic [CNT_W-1:0]    drop_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state, state_nxt;
  logic [WIDTH-1:0] main_data, main_nxt;
  logic [WIDTH-1:0] skid_data, skid_nxt;
  logic [CNT_W-1:0] drop_nxt;
  logic             in_ready_q;
  logic             main_valid, skid_valid;
  logic             in_fire, out_fire;
  logic [CNT_W:0]   drop_sum;

  assign main_valid = (state != EMPTY);
  assign skid_valid = (state == FULL);
  assign in_fire    = bus.in_valid & in_ready_q;
  assign out_fire   = main_valid & bus.out_ready;

  // Bubbles must be inert downstream, so control bits are zeroed whenever
  // nothing valid is being presented.
  assign bus.out_valid = main_valid;
  assign bus.out_data  = main_valid ? main_data : (main_data & ~CTRL_MASK);
  assign bus.in_ready  = in_ready_q;
  assign count         = state;

  // One extra bit so the saturation test sees the carry.
  assign drop_sum = {1'b0, drop_cnt}
                  + {{CNT_W{1'b0}}, main_valid}
                  + {{CNT_W{1'b0}}, skid_valid};

  always_comb begin
    state_nxt = state;
    main_nxt  = main_data;
    skid_nxt  = skid_data;
    drop_nxt  = drop_cnt;

    if (flush) begin
      // Transfers in the flush cycle are ignored on both sides.
      state_nxt = EMPTY;
      if (CLEAR_DATA) begin
        main_nxt = '0;
        skid_nxt = '0;
      end else begin
        main_nxt = main_data & ~CTRL_MASK;
        skid_nxt = skid_data & ~CTRL_MASK;
      end
      drop_nxt = (drop_sum > {1'b0, CNT_MAX}) ? CNT_MAX : drop_sum[CNT_W-1:0];
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_fire) begin
            state_nxt = ONE;
            main_nxt  = bus.in_data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_nxt = bus.in_data;
          end else if (in_fire) begin
            state_nxt = FULL;
            skid_nxt  = bus.in_data;
          end else if (out_fire) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only the drain path exists.
          if (out_fire) begin
            state_nxt = ONE;
            main_nxt  = skid_data;
          end
        end
        default: begin
          state_nxt = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      main_data  <= '0;
      skid_data  <= '0;
      drop_cnt   <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_nxt;
      main_data  <= main_nxt;
      skid_data  <= skid_nxt;
      drop_cnt   <= drop_nxt;
      // Registered ready: low exactly when the skid entry will be occupied.
      in_ready_q <= (state_nxt != FULL);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_skid
// Description : Directed self-checking bench for pipe_stage_skid. Two
//               instances share stimulus: dut (CNT_W=8, CLEAR_DATA=0) and
//               dut2 (CNT_W=2, CLEAR_DATA=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_skid;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic [1:0] count, count2;
  logic [7:0] drop_cnt;
  logic [1:0] drop_cnt2;
  int         n_checks = 0;
  int         n_fail   = 0;

  pipe_stage_skid_if #(.WIDTH(8)) bus  ();
  pipe_stage_skid_if #(.WIDTH(8)) bus2 ();

  assign bus2.in_valid  = bus.in_valid;
  assign bus2.in_data   = bus.in_data;
  assign bus2.out_ready = bus.out_ready;

  pipe_stage_skid #(
    .WIDTH(8), .CTRL_MASK(8'hF0), .CLEAR_DATA(1'b0), .CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus),
    .count(count), .drop_cnt(drop_cnt)
  );

  pipe_stage_skid #(
    .WIDTH(8), .CTRL_MASK(8'hF0), .CLEAR_DATA(1'b1), .CNT_W(2)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus2),
    .count(count2), .drop_cnt(drop_cnt2)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Fill the stage to FULL with a in main and b in skid (out_ready held 0).
  task automatic fill_full(input logic [7:0] a, input logic [7:0] b);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = a;
    tick();
    bus.in_data   = b;
    tick();
    bus.in_valid  = 1'b0;
  endtask

  task automatic test_reset;
    bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.out_ready = 1'b0;
    flush = 1'b0; rst_n = 1'b0;
    tick(); tick();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    n_checks++; if (bus.out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h expected 00", bus.out_data); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    n_checks++; if (count !== 2'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_checks++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); end
    n_checks++; if (drop_cnt2 !== 2'd0) begin n_fail++; $display("FAIL reset_drop_cnt2: got %0d expected 0", drop_cnt2); end
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back;
    logic [7:0] vec [3];
    vec[0] = 8'hA5; vec[1] = 8'h3C; vec[2] = 8'h81;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_data = vec[i];
      tick();
      if (i == 2) bus.in_valid = 1'b0;
      n_checks++; if (bus.out_data !== vec[i]) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, bus.out_data, vec[i]); end
      n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b expected 1", i, bus.out_valid); end
      n_checks++; if (count !== 2'd1) begin n_fail++; $display("FAIL b2b_count[%0d]: got %0d expected 1", i, count); end
      n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready[%0d]: got %b expected 1", i, bus.in_ready); end
    end
    tick();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain_valid: got %b expected 0", bus.out_valid); end
    n_checks++; if (count !== 2'd0) begin n_fail++; $display("FAIL b2b_drain_count: got %0d expected 0", count); end
    // Bubble: 8'h81 with control nibble masked.
    n_checks++; if (bus.out_data !== 8'h01) begin n_fail++; $display("FAIL b2b_bubble_mask: got %h expected 01", bus.out_data); end
  endtask

  task automatic test_stall;
    fill_full(8'h11, 8'h22);
    n_checks++; if (count !== 2'd2) begin n_fail++; $display("FAIL stall_count_full: got %0d expected 2", count); end
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: got %b expected 0", bus.in_ready); end
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h33;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (count !== 2'd2 || bus.out_data !== 8'h11) begin n_fail++; $display("FAIL stall_hold[%0d]: got count %0d data %h expected 2 11", i, count, bus.out_data); end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    n_checks++; if (bus.out_data !== 8'h22 || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_second: got %h/%b expected 22/1", bus.out_data, bus.out_valid); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_ready_back: got %b expected 1", bus.in_ready); end
    n_checks++; if (count !== 2'd1) begin n_fail++; $display("FAIL stall_count_one: got %0d expected 1", count); end
    tick();
    // 8'h33 was never accepted, so the stage is now empty.
    n_checks++; if (bus.out_valid !== 1'b0 || count !== 2'd0) begin n_fail++; $display("FAIL stall_no_33: got valid %b count %0d expected 0 0", bus.out_valid, count); end
  endtask

  task automatic test_flush_full;
    fill_full(8'hF7, 8'hE2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b expected 0", bus.out_valid); end
    n_checks++; if (bus.out_data !== 8'h07) begin n_fail++; $display("FAIL flush_data: got %h expected 07", bus.out_data); end
    n_checks++; if (count !== 2'd0) begin n_fail++; $display("FAIL flush_count: got %0d expected 0", count); end
    n_checks++; if (drop_cnt !== 8'd2) begin n_fail++; $display("FAIL flush_drop_cnt: got %0d expected 2", drop_cnt); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_flush_with_input;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h99;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b0 || count !== 2'd0) begin n_fail++; $display("FAIL flush_discard: got valid %b count %0d expected 0 0", bus.out_valid, count); end
    n_checks++; if (drop_cnt !== 8'd2) begin n_fail++; $display("FAIL flush_empty_drop: got %0d expected 2", drop_cnt); end
    tick();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_discard_late: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_saturate;
    logic [1:0] exp2 [3];
    logic [7:0] exp1 [3];
    exp2[0] = 2'd2; exp2[1] = 2'd3; exp2[2] = 2'd3;
    exp1[0] = 8'd2; exp1[1] = 8'd4; exp1[2] = 8'd6;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fill_full(8'h5A, 8'hC3);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      n_checks++; if (drop_cnt2 !== exp2[i]) begin n_fail++; $display("FAIL sat_drop_cnt2[%0d]: got %0d expected %0d", i, drop_cnt2, exp2[i]); end
      n_checks++; if (drop_cnt !== exp1[i]) begin n_fail++; $display("FAIL sat_drop_cnt[%0d]: got %0d expected %0d", i, drop_cnt, exp1[i]); end
    end
    n_checks++; if (bus2.out_data !== 8'h00) begin n_fail++; $display("FAIL clear_data_out: got %h expected 00", bus2.out_data); end
    n_checks++; if (bus.out_data !== 8'h0A) begin n_fail++; $display("FAIL keep_data_out: got %h expected 0a", bus.out_data); end
  endtask

  task automatic test_async_reset;
    fill_full(8'hF7, 8'hE2);
    n_checks++; if (count !== 2'd2) begin n_fail++; $display("FAIL arst_pre_count: got %0d expected 2", count); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %b expected 0", bus.out_valid); end
    n_checks++; if (bus.out_data !== 8'h00) begin n_fail++; $display("FAIL arst_data: got %h expected 00", bus.out_data); end
    n_checks++; if (count !== 2'd0) begin n_fail++; $display("FAIL arst_count: got %0d expected 0", count); end
    n_checks++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL arst_drop_cnt: got %0d expected 0", drop_cnt); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL arst_in_ready: got %b expected 1", bus.in_ready); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;
    test_reset();
    test_back_to_back();
    test_stall();
    test_flush_full();
    test_flush_with_input();
    test_saturate();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised pipeline stage register with a valid/ready handshake, a 2-entry skid buffer, synchronous flush, and control-field bubble masking.
- Next-generation replacement for the fixed-field stage registers between D/E/M/W.
- Any stage bundle is packed into one WIDTH-bit vector. CTRL_MASK selects the control bits (RegWrite, MemWrite, Jal, sys, ...) that are zeroed on bubbles and flushes.
- Sits between two pipeline stages. Backpressure from downstream replaces ad-hoc stall wiring.

Parameters:
- WIDTH, 32, width of the packed stage payload.
- CTRL_MASK, {WIDTH{1'b0}}, per-bit mask; 1 = control bit, forced 0 on flush and whenever out_valid=0.
- CLEAR_DATA, 0, 1 = flush also zeroes non-control bits of both entries; 0 = non-control bits keep their value.
- CNT_W, 8, width of the saturating flush-drop counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous flush, highest priority.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  stage can accept; registered.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  payload valid to downstream.
- out_ready  in  1  downstream accepts (0 = stall).
- out_data  out  WIDTH  payload to downstream.
- count  out  2  occupancy, 0..2.
- drop_cnt  out  CNT_W  valid entries discarded by flush; saturating.

Behaviour:
- in_fire = in_valid & in_ready. out_fire = out_valid & out_ready.
- Storage: main register (drives the output) and skid register. out_valid = main_valid. in_ready = !skid_valid, taken directly from a flop.
- Reset (rst_n=0, async):
  - main_valid=0, skid_valid=0.
  - main and skid data = 0.
  - drop_cnt=0, count=0, in_ready=1, out_valid=0, out_data=0.
- out_data = main_data with CTRL_MASK bits forced to 0 whenever out_valid=0, so bubbles are inert downstream.
- States, equal to count:
  - EMPTY(0):
    - in_fire -> ONE, main<=in_data.
  - ONE(1):
    - in_fire & out_fire -> ONE, main<=in_data.
    - in_fire & !out_fire -> FULL, skid<=in_data.
    - out_fire only -> EMPTY.
    - Neither -> hold.
  - FULL(2):
    - in_ready=0, so no in_fire is possible.
    - out_fire -> ONE, main<=skid.
    - Otherwise hold.
- Latency: in_fire at edge N gives out_valid at N+1 when the stage was EMPTY, or when ONE with out_fire. Sustained throughput is 1 per cycle with out_ready=1.
- Ordering is strict FIFO. The skid entry is never overtaken.
- The payload is never modified except by flush or CTRL_MASK output masking.
- flush=1 at an edge:
  - main_valid<=0, skid_valid<=0; state goes to EMPTY.
  - CTRL_MASK bits of main and skid <= 0.
  - If CLEAR_DATA=1, all bits <= 0.
  - Any in_fire or out_fire that cycle is ignored: the input is discarded, and the output is not considered consumed by this stage.
  - in_ready=1 the following cycle.
- drop_cnt adds (main_valid + skid_valid) on each flush edge and saturates at 2^CNT_W-1, with no wrap. It is cleared only by reset.
- Flush with an empty stage is legal: no counter change.
- Reset asserted mid-transfer clears everything immediately, without waiting for a clock. Release is synchronous to the next edge as seen by the logic; there is no internal synchroniser.
- A change on in_data while in_valid=1 and in_ready=0 has no effect.

Test Plan:
- Reset release, WIDTH=8, CTRL_MASK=8'hF0, out_ready=1, drive 8'hA5,8'h3C,8'h81 back-to-back -> out_data 8'hA5,8'h3C,8'h81 on the three consecutive cycles after each input. out_valid stays 1 throughout, count=1 throughout, and in_ready stays 1.
- out_ready=0, drive 8'h11 then 8'h22 -> count reaches 2 and in_ready=0. Hold out_ready=0 and drive 8'h33 for 3 cycles -> 8'h33 is not accepted. Raise out_ready -> outputs 8'h11, then 8'h22; in_ready returns to 1 the cycle after 8'h11 leaves.
- FULL with 8'hF7 in main and 8'hE2 in skid, pulse flush with CLEAR_DATA=0 -> out_valid=0 and out_data=8'h07. count=0, drop_cnt=2, and in_ready=1 on the next cycle.
- Flush and in_fire of 8'h99 in the same cycle -> 8'h99 is discarded and out_valid stays 0 next cycle. Flush with an empty stage -> drop_cnt unchanged.
- CNT_W=2, 3 flushes of a FULL stage -> drop_cnt goes 2, 3, 3 (saturates).
- Assert rst_n=0 between clock edges while FULL -> out_valid=0, out_data=0, count=0, drop_cnt=0 before the next edge.
